gf2_trinomial_reduce: RTL and testbench



---
 rtl/gf2_red_pkg.sv | 21 ++
 rtl/gf2_trinomial_reduce_if.sv | 41 ++++
 rtl/gf2_red_fold.sv | 29 ++
 rtl/gf2_trinomial_reduce.sv | 109 ++++++++++
 tb/tb_gf2_trinomial_reduce.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gf2_red_pkg.sv
// Shared defaults, FSM state type and cycle-count helper for the GF(2^M) trinomial reducer.
// Optional feature macro used by this slice: GF2_RED_ZERO_FLAG_EN.
package gf2_red_pkg;

  localparam int GF2_RED_N = 192;
  localparam int GF2_RED_M = 191;
  localparam int GF2_RED_K = 9;
  localparam int GF2_RED_D = 8;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } red_state_e;

  // Number of REDUCE cycles: ceil((2N-M)/D).
  function automatic int calc_cycles(input int n, input int m, input int d);
    return (2 * n - m + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf2_trinomial_reduce_if.sv
// Valid/ready handshake bundle between the product source, the reducer and the result consumer.
// out_zero exists only when GF2_RED_ZERO_FLAG_EN is defined.
interface gf2_trinomial_reduce_if
  import gf2_red_pkg::*;
#(
  parameter int N = GF2_RED_N,
  parameter int M = GF2_RED_M
);

  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_res;
  logic             busy;
`ifdef GF2_RED_ZERO_FLAG_EN
  logic             out_zero;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_res, busy, out_zero
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_res, busy, out_zero
  );
`else
  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_res, busy
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_res, busy
  );
`endif

endinterface

// File: rtl/gf2_red_fold.sv
// Combinational single-digit fold: every set bit in [max(hi-D+1, M), hi] is cleared and
// reinjected at i-M+K and i-M, using x^M = x^K + 1.
module gf2_red_fold #(
  parameter int N = 192,
  parameter int M = 191,
  parameter int K = 9,
  parameter int D = 8
) (
  input  logic [2*N-1:0]         acc,
  input  logic [$clog2(2*N)-1:0] hi,
  output logic [2*N-1:0]         acc_next
);

  localparam int W = 2 * N;

  // Targets always fall below the window because D <= M-K, so reading acc for the
  // window test while accumulating into acc_next is order-independent.
  always_comb begin
    acc_next = acc;
    for (int i = M; i < W; i++) begin
      if ((int'(hi) >= i) && ((int'(hi) - i) < D) && acc[i]) begin
        acc_next[i]         = 1'b0;
        acc_next[i - M + K] = acc_next[i - M + K] ^ 1'b1;
        acc_next[i - M]     = acc_next[i - M] ^ 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf2_trinomial_reduce.sv
// Digit-serial reduction of a 2N-bit carry-less product modulo x^M + x^K + 1, D bits per cycle.
// Define GF2_RED_ZERO_FLAG_EN to add the registered out_zero flag.
module gf2_trinomial_reduce
  import gf2_red_pkg::*;
#(
  parameter int N = GF2_RED_N,
  parameter int M = GF2_RED_M,
  parameter int K = GF2_RED_K,
  parameter int D = GF2_RED_D
) (
  input  logic                   clk,
  input  logic                   rst,
  gf2_trinomial_reduce_if.slave  bus
);

  localparam int W  = 2 * N;
  localparam int PW = $clog2(W);

  if ((D < 1) || (D > M - K) || (K < 1) || (K >= M) || (W <= M)) begin : g_param_check
    $error("gf2_trinomial_reduce: illegal parameters (need 0<K<M<2N and 1<=D<=M-K)");
  end

  red_state_e      state_q, state_d;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    acc_fold;
  logic [PW-1:0]   hi_q;
  logic            last_digit;

  gf2_red_fold #(.N(N), .M(M), .K(K), .D(D)) u_fold (
    .acc      (acc_q),
    .hi       (hi_q),
    .acc_next (acc_fold)
  );

  // The current digit's lower edge reaches M once hi-D+1 <= M.
  assign last_digit = (int'(hi_q) < (M + D));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = REDUCE;
      end
      REDUCE: begin
        bus.busy = 1'b1;
        if (last_digit) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      hi_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            acc_q <= bus.in_prod;
            hi_q  <= PW'(W - 1);
          end
        end
        REDUCE: begin
          acc_q <= acc_fold;
          hi_q  <= hi_q - PW'(D);
        end
        default: ;
      endcase
    end
  end

  // The accumulator is frozen in DONE, so the result needs no separate holding register.
  assign bus.out_res = (state_q == DONE) ? acc_q[M-1:0] : '0;

`ifdef GF2_RED_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if ((state_q == REDUCE) && last_digit) begin
      zero_q <= (acc_fold[M-1:0] == '0);
    end else if ((state_q == DONE) && bus.out_ready) begin
      zero_q <= 1'b0;
    end
  end

  assign bus.out_zero = zero_q;
`endif

endmodule

// File: tb/tb_gf2_trinomial_reduce.sv
// Self-checking bench: three reducers (D = 1, 8, 182) share one stimulus stream and are
// compared against an interleaved shift-and-add modular multiply reference.
module tb_gf2_trinomial_reduce;
  import gf2_red_pkg::*;

  localparam int N = GF2_RED_N;
  localparam int M = GF2_RED_M;
  localparam int K = GF2_RED_K;
  localparam int W = 2 * N;
  localparam int C1   = 193;
  localparam int C8   = 25;
  localparam int C182 = 2;
  localparam int NUM_RANDOM = 200;

  typedef logic [W-1:0] prod_t;
  typedef logic [M-1:0] elem_t;

  typedef struct {
    string name;
    prod_t prod;
    elem_t res;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  in_valid = 1'b0;
  logic  out_ready = 1'b0;
  prod_t in_prod = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  gf2_trinomial_reduce_if #(.N(N), .M(M)) b1 ();
  gf2_trinomial_reduce_if #(.N(N), .M(M)) b8 ();
  gf2_trinomial_reduce_if #(.N(N), .M(M)) b182 ();

  assign b1.in_valid    = in_valid;
  assign b1.in_prod     = in_prod;
  assign b1.out_ready   = out_ready;
  assign b8.in_valid    = in_valid;
  assign b8.in_prod     = in_prod;
  assign b8.out_ready   = out_ready;
  assign b182.in_valid  = in_valid;
  assign b182.in_prod   = in_prod;
  assign b182.out_ready = out_ready;

  gf2_trinomial_reduce #(.N(N), .M(M), .K(K), .D(1)) dut_d1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );
  gf2_trinomial_reduce #(.N(N), .M(M), .K(K), .D(8)) dut_d8 (
    .clk (clk), .rst (rst), .bus (b8.slave)
  );
  gf2_trinomial_reduce #(.N(N), .M(M), .K(K), .D(182)) dut_d182 (
    .clk (clk), .rst (rst), .bus (b182.slave)
  );

  function automatic logic all_in_ready();
    return b1.in_ready & b8.in_ready & b182.in_ready;
  endfunction

  function automatic logic any_in_ready();
    return b1.in_ready | b8.in_ready | b182.in_ready;
  endfunction

  function automatic logic any_out_valid();
    return b1.out_valid | b8.out_valid | b182.out_valid;
  endfunction

  function automatic logic any_busy();
    return b1.busy | b8.busy | b182.busy;
  endfunction

  function automatic prod_t clmul(input elem_t a, input elem_t b);
    prod_t p = '0;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ (prod_t'(a) << i);
    end
    return p;
  endfunction

  // Horner-style a*b mod f: multiply by x (x^M -> x^K + 1) and add a per set bit of b.
  function automatic elem_t mulmod(input elem_t a, input elem_t b);
    elem_t r = '0;
    logic  carry;
    for (int i = M - 1; i >= 0; i--) begin
      carry = r[M-1];
      r = r << 1;
      if (carry) r = r ^ elem_t'((1 << K) | 1);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic elem_t rand_elem();
    logic [191:0] t;
    for (int w = 0; w < 6; w++) t[w*32 +: 32] = $urandom;
    return t[M-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input prod_t act, input prod_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input prod_t p);
    int guard = 0;
    while (!all_in_ready() && (guard < 10)) begin
      tick();
      guard++;
    end
    checkOutput("in_ready before accept", prod_t'(all_in_ready()), prod_t'(1));
    in_prod  = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; leaves all outputs valid and unacknowledged.
  task automatic collectResult(input elem_t exp, input string nm);
    int lat1 = -1;
    int lat8 = -1;
    int lat182 = -1;
    int cyc = 0;
    while (((lat1 < 0) || (lat8 < 0) || (lat182 < 0)) && (cyc < C1 + 10)) begin
      tick();
      cyc++;
      if ((lat1 < 0) && b1.out_valid) lat1 = cyc;
      if ((lat8 < 0) && b8.out_valid) lat8 = cyc;
      if ((lat182 < 0) && b182.out_valid) lat182 = cyc;
    end
    checkOutput({nm, " latency D=1"}, prod_t'(lat1), prod_t'(C1));
    checkOutput({nm, " latency D=8"}, prod_t'(lat8), prod_t'(C8));
    checkOutput({nm, " latency D=182"}, prod_t'(lat182), prod_t'(C182));
    checkOutput({nm, " res D=1"}, prod_t'(b1.out_res), prod_t'(exp));
    checkOutput({nm, " res D=8"}, prod_t'(b8.out_res), prod_t'(exp));
    checkOutput({nm, " res D=182"}, prod_t'(b182.out_res), prod_t'(exp));
`ifdef GF2_RED_ZERO_FLAG_EN
    checkOutput({nm, " zero D=1"}, prod_t'(b1.out_zero), prod_t'(exp == '0));
    checkOutput({nm, " zero D=8"}, prod_t'(b8.out_zero), prod_t'(exp == '0));
    checkOutput({nm, " zero D=182"}, prod_t'(b182.out_zero), prod_t'(exp == '0));
`endif
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("in_ready after handshake", prod_t'(all_in_ready()), prod_t'(1));
    checkOutput("out_valid after handshake", prod_t'(any_out_valid()), '0);
  endtask

  vec_t vecs[$];

  initial begin
    elem_t a, b, e1, e2;
    prod_t p1, p2;

    vecs.push_back('{"x^191", prod_t'(1) << 191, elem_t'(20'h00201)});
    vecs.push_back('{"x^382", prod_t'(1) << 382, elem_t'(20'h40001)});
    vecs.push_back('{"x^383", prod_t'(1) << 383, elem_t'(20'h80002)});
    vecs.push_back('{"x^200", prod_t'(1) << 200, elem_t'(20'h40200)});
    vecs.push_back('{"low 0x1234", prod_t'(16'h1234), elem_t'(16'h1234)});
    vecs.push_back('{"zero", '0, '0});
    vecs.push_back('{"trinomial", (prod_t'(1) << 191) | prod_t'(10'h201), '0});
    vecs.push_back('{"all low ones", prod_t'({M{1'b1}}), {M{1'b1}}});

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("reset in_ready", prod_t'(all_in_ready()), prod_t'(1));
    checkOutput("reset out_valid", prod_t'(any_out_valid()), '0);
    checkOutput("reset busy", prod_t'(any_busy()), '0);
    checkOutput("reset out_res", prod_t'(b1.out_res | b8.out_res | b182.out_res), '0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].prod);
      checkOutput({vecs[i].name, " busy"}, prod_t'(b8.busy), prod_t'(1));
      collectResult(vecs[i].res, vecs[i].name);
      releaseOutput();
    end

    for (int n = 0; n < NUM_RANDOM; n++) begin
      a = rand_elem();
      b = rand_elem();
      applyStimulus(clmul(a, b));
      collectResult(mulmod(a, b), "random");
      releaseOutput();
    end

    // Output stall with a competing input that must wait for the handshake.
    a = rand_elem();
    b = rand_elem();
    p1 = clmul(a, b);
    e1 = mulmod(a, b);
    a = rand_elem();
    b = rand_elem();
    p2 = clmul(a, b);
    e2 = mulmod(a, b);
    applyStimulus(p1);
    collectResult(e1, "stall first");
    in_prod  = p2;
    in_valid = 1'b1;
    for (int s = 0; s < 10; s++) begin
      tick();
      checkOutput("stall res D=8", prod_t'(b8.out_res), prod_t'(e1));
      checkOutput("stall res D=1", prod_t'(b1.out_res), prod_t'(e1));
      checkOutput("stall in_ready", prod_t'(any_in_ready()), '0);
      checkOutput("stall out_valid", prod_t'(b8.out_valid), prod_t'(1));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("stall release in_ready", prod_t'(all_in_ready()), prod_t'(1));
    checkOutput("stall release out_valid", prod_t'(any_out_valid()), '0);
    tick();
    in_valid = 1'b0;
    checkOutput("stall second accepted", prod_t'(b8.busy), prod_t'(1));
    collectResult(e2, "stall second");
    releaseOutput();

    // Reset partway through a reduction discards the in-flight product.
    a = rand_elem();
    b = rand_elem();
    applyStimulus(clmul(a, b));
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset in_ready", prod_t'(all_in_ready()), prod_t'(1));
    checkOutput("midreset out_valid", prod_t'(any_out_valid()), '0);
    checkOutput("midreset busy", prod_t'(any_busy()), '0);
    checkOutput("midreset out_res", prod_t'(b1.out_res | b8.out_res | b182.out_res), '0);
    applyStimulus(prod_t'(1) << 191);
    collectResult(elem_t'(20'h00201), "after reset");
    releaseOutput();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
